// File: rtl/sonata_pin_debounce.sv
// rtl/sonata_pin_debounce.sv - per-pin synchroniser, glitch filter, edge pulses and sticky edge flags
// Conditions raw board inputs before the pinmux; all outputs are registered.
module sonata_pin_debounce #(
    parameter int                  NUM_PINS    = 8,
    parameter int                  SYNC_STAGES = 2,
    parameter int                  CNT_W       = 16,
    parameter logic [NUM_PINS-1:0] RESET_VAL   = '1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NUM_PINS-1:0] pins_i,
    input  logic [CNT_W-1:0]    debounce_cycles_i,
    output logic [NUM_PINS-1:0] pins_o,
    output logic [NUM_PINS-1:0] rise_o,
    output logic [NUM_PINS-1:0] fall_o,
    output logic [NUM_PINS-1:0] event_o,
    input  logic [NUM_PINS-1:0] event_clr_i
);

    logic [NUM_PINS-1:0] sync_q [SYNC_STAGES];
    logic [NUM_PINS-1:0] sync;

    logic [NUM_PINS-1:0] stable_q, stable_d;
    logic [CNT_W-1:0]    cnt_q [NUM_PINS];
    logic [CNT_W-1:0]    cnt_d [NUM_PINS];
    logic [NUM_PINS-1:0] rise_q, rise_d;
    logic [NUM_PINS-1:0] fall_q, fall_d;
    logic [NUM_PINS-1:0] event_q, event_d;

    assign sync = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= RESET_VAL;
            end
        end else begin
            sync_q[0] <= pins_i;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    // Using >= lets a lowered threshold take effect on the very next mismatching cycle.
    always_comb begin
        stable_d = stable_q;
        rise_d   = '0;
        fall_d   = '0;
        for (int i = 0; i < NUM_PINS; i++) begin
            cnt_d[i] = '0;
            if (sync[i] != stable_q[i]) begin
                if (cnt_q[i] >= debounce_cycles_i) begin
                    stable_d[i] = sync[i];
                    rise_d[i]   = sync[i];
                    fall_d[i]   = ~sync[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
        event_d = (event_q & ~event_clr_i) | rise_q | fall_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stable_q <= RESET_VAL;
            rise_q   <= '0;
            fall_q   <= '0;
            event_q  <= '0;
            for (int i = 0; i < NUM_PINS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            stable_q <= stable_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            event_q  <= event_d;
            for (int i = 0; i < NUM_PINS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign pins_o  = stable_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;
    assign event_o = event_q;

endmodule

// File: tb/tb_sonata_pin_debounce.sv
// tb/tb_sonata_pin_debounce.sv - directed scoreboard bench for sonata_pin_debounce
module tb_sonata_pin_debounce;

    localparam int N  = 8;
    localparam int CW = 16;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [N-1:0]  pins_i;
    logic [CW-1:0] debounce_cycles_i;
    logic [N-1:0]  event_clr_i;
    logic [N-1:0]  pins_o, rise_o, fall_o, event_o;

    sonata_pin_debounce #(
        .NUM_PINS(N), .SYNC_STAGES(2), .CNT_W(CW), .RESET_VAL('1)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .pins_i(pins_i),
        .debounce_cycles_i(debounce_cycles_i),
        .pins_o(pins_o),
        .rise_o(rise_o),
        .fall_o(fall_o),
        .event_o(event_o),
        .event_clr_i(event_clr_i)
    );

    typedef struct {
        string        tag;
        int           cyc;
        logic [N-1:0] pins;
        logic [N-1:0] rise;
        logic [N-1:0] fall;
        logic [N-1:0] evt;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input exp_t e);
        n_vec++;
        assert (pins_o === e.pins) else begin
            n_err++;
            $error("FAIL %s pins_o got %h exp %h", e.tag, pins_o, e.pins);
        end
        n_vec++;
        assert (rise_o === e.rise) else begin
            n_err++;
            $error("FAIL %s rise_o got %h exp %h", e.tag, rise_o, e.rise);
        end
        n_vec++;
        assert (fall_o === e.fall) else begin
            n_err++;
            $error("FAIL %s fall_o got %h exp %h", e.tag, fall_o, e.fall);
        end
        n_vec++;
        assert (event_o === e.evt) else begin
            n_err++;
            $error("FAIL %s event_o got %h exp %h", e.tag, event_o, e.evt);
        end
    endtask

    // Outputs are sampled on the falling edge, well away from the active edge.
    always @(negedge clk_i) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                check(sb[i]);
                sb.delete(i);
            end else if (sb[i].cyc < cyc) begin
                n_vec++;
                n_err++;
                $error("FAIL %s missed at cycle %0d exp cycle %0d", sb[i].tag, cyc, sb[i].cyc);
                sb.delete(i);
            end
        end
    end

    task automatic exp_at(input string tag, input int off,
                          input logic [N-1:0] p, input logic [N-1:0] r,
                          input logic [N-1:0] f, input logic [N-1:0] e);
        exp_t x;
        x.tag = tag; x.cyc = cyc + off; x.pins = p; x.rise = r; x.fall = f; x.evt = e;
        sb.push_back(x);
    endtask

    task automatic exp_span(input string tag, input int from, input int to,
                            input logic [N-1:0] p, input logic [N-1:0] r,
                            input logic [N-1:0] f, input logic [N-1:0] e);
        for (int k = from; k <= to; k++) exp_at(tag, k, p, r, f, e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    initial begin
        rst_i = 1'b1; pins_i = 8'h00; debounce_cycles_i = 16'd0; event_clr_i = 8'h00;

        // reset, then D=0 pure synchroniser on pin 0
        exp_span("rst_state", 1, 2, 8'hFF, 8'h00, 8'h00, 8'h00);
        tick(2);
        rst_i = 1'b0; pins_i = 8'hFE;
        exp_span("d0_wait", 1, 2, 8'hFF, 8'h00, 8'h00, 8'h00);
        exp_at("d0_fall", 3, 8'hFE, 8'h00, 8'h01, 8'h00);
        exp_at("d0_event", 4, 8'hFE, 8'h00, 8'h00, 8'h01);
        tick(4);
        event_clr_i = 8'h01;
        exp_at("d0_clr", 1, 8'hFE, 8'h00, 8'h00, 8'h00);
        tick(1);
        event_clr_i = 8'h00;

        // glitch filter D=3 on pin 2
        debounce_cycles_i = 16'd3;
        pins_i = 8'hFA;
        exp_span("glitch3", 1, 10, 8'hFE, 8'h00, 8'h00, 8'h00);
        tick(3); pins_i = 8'hFE; tick(8);
        pins_i = 8'hFA;
        exp_span("low4_wait", 1, 5, 8'hFE, 8'h00, 8'h00, 8'h00);
        exp_at("low4_fall", 6, 8'hFA, 8'h00, 8'h04, 8'h00);
        exp_span("low4_held", 7, 9, 8'hFA, 8'h00, 8'h00, 8'h04);
        exp_at("low4_rise", 10, 8'hFE, 8'h04, 8'h00, 8'h04);
        exp_at("low4_after", 11, 8'hFE, 8'h00, 8'h00, 8'h04);
        tick(4); pins_i = 8'hFE; tick(8);
        event_clr_i = 8'hFF;
        exp_at("s2_clr", 1, 8'hFE, 8'h00, 8'h00, 8'h00);
        tick(1);
        event_clr_i = 8'h00;

        // bounce D=5 on pin 3, then hold low
        debounce_cycles_i = 16'd5;
        exp_span("bounce_wait", 1, 15, 8'hFE, 8'h00, 8'h00, 8'h00);
        exp_at("bounce_fall", 16, 8'hF6, 8'h00, 8'h08, 8'h00);
        exp_span("bounce_after", 17, 19, 8'hF6, 8'h00, 8'h00, 8'h08);
        pins_i = 8'hF6; tick(2);
        pins_i = 8'hFE; tick(2);
        pins_i = 8'hF6; tick(2);
        pins_i = 8'hFE; tick(2);
        pins_i = 8'hF6; tick(12);
        event_clr_i = 8'hFF;
        exp_at("s3_clr", 1, 8'hF6, 8'h00, 8'h00, 8'h00);
        tick(1);
        event_clr_i = 8'h00;

        // threshold lowered from 100 to 10 after 20 mismatching cycles on pin 5
        debounce_cycles_i = 16'd100;
        pins_i = 8'hD6;
        exp_span("thr_wait", 1, 22, 8'hF6, 8'h00, 8'h00, 8'h00);
        exp_at("thr_fall", 23, 8'hD6, 8'h00, 8'h20, 8'h00);
        exp_span("thr_after", 24, 26, 8'hD6, 8'h00, 8'h00, 8'h20);
        tick(22);
        debounce_cycles_i = 16'd10;
        tick(5);
        event_clr_i = 8'hFF;
        exp_at("s4_clr", 1, 8'hD6, 8'h00, 8'h00, 8'h00);
        tick(1);
        event_clr_i = 8'h00;

        // clear colliding with a rise on pin 1
        debounce_cycles_i = 16'd0;
        pins_i = 8'hD4;
        exp_span("clr_wait", 1, 2, 8'hD6, 8'h00, 8'h00, 8'h00);
        exp_at("clr_fall", 3, 8'hD4, 8'h00, 8'h02, 8'h00);
        exp_at("clr_fevt", 4, 8'hD4, 8'h00, 8'h00, 8'h02);
        exp_span("clr_cleared", 5, 7, 8'hD4, 8'h00, 8'h00, 8'h00);
        exp_at("clr_rise", 8, 8'hD6, 8'h02, 8'h00, 8'h00);
        exp_at("clr_collide", 9, 8'hD6, 8'h00, 8'h00, 8'h02);
        exp_at("clr_later", 10, 8'hD6, 8'h00, 8'h00, 8'h00);
        tick(4);
        event_clr_i = 8'h02; tick(1);
        event_clr_i = 8'h00; pins_i = 8'hD6; tick(3);
        event_clr_i = 8'h02; tick(2);
        event_clr_i = 8'h00; tick(1);

        // reset in the middle of a D=50 count on pin 4
        debounce_cycles_i = 16'd50;
        pins_i = 8'hEF;
        exp_span("mid_wait", 1, 32, 8'hD6, 8'h00, 8'h00, 8'h00);
        tick(32);
        rst_i = 1'b1;
        exp_at("mid_rst", 1, 8'hFF, 8'h00, 8'h00, 8'h00);
        tick(1);
        rst_i = 1'b0;
        exp_span("post_wait", 1, 52, 8'hFF, 8'h00, 8'h00, 8'h00);
        exp_at("post_fall", 53, 8'hEF, 8'h00, 8'h10, 8'h00);
        exp_at("post_event", 54, 8'hEF, 8'h00, 8'h00, 8'h10);
        tick(56);

        for (int i = 0; i < sb.size(); i++) begin
            n_vec++;
            n_err++;
            $error("FAIL %s never checked exp cycle %0d", sb[i].tag, sb[i].cyc);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sonata_pin_debounce.md
Name: sonata_pin_debounce

Overview:
- Input-conditioning stage directly upstream of the Sonata pinmux.
- Takes raw asynchronous board input pins, such as UART RX lines, the CIPO of the app SPI / ethernet MAC, mikroBUS inputs and microSD DAT0.
- Per pin: synchronises to the system clock, rejects glitches shorter than a programmable cycle count, and produces a clean level plus rise/fall pulses and sticky edge flags.
- The pinmux and peripherals consume the clean levels from `pins_o`.

Parameters:
- NUM_PINS, 8, number of conditioned pins (matches the block-level input pin count).
- SYNC_STAGES, 2, flop stages in each synchroniser chain; legal range 2..4.
- CNT_W, 16, width of each debounce counter and of the threshold input.
- RESET_VAL, all-ones [NUM_PINS-1:0], reset level of the synchroniser chain and of `pins_o`. Idle-high suits UART RX.

Ports:
- clk_i  input  1  system clock; single clock domain.
- rst_i  input  1  synchronous, active-high reset.
- pins_i  input  NUM_PINS  raw asynchronous pin levels.
- debounce_cycles_i  input  CNT_W  threshold D, shared by all pins; quasi-static, may change at any time.
- pins_o  output  NUM_PINS  debounced, synchronised levels.
- rise_o  output  NUM_PINS  one-cycle pulse when `pins_o[i]` goes 0->1.
- fall_o  output  NUM_PINS  one-cycle pulse when `pins_o[i]` goes 1->0.
- event_o  output  NUM_PINS  sticky flag, set by any edge on pin i.
- event_clr_i  input  NUM_PINS  per-pin clear for `event_o`; level-sensitive.

Behaviour:
- Reset (rst_i high at a clock edge): all synchroniser flops <= RESET_VAL; `pins_o` <= RESET_VAL; counters <= 0; `rise_o`, `fall_o`, `event_o` <= 0. Reset mid-count discards the partial count and returns `pins_o` to RESET_VAL with no edge pulse generated.
- Synchroniser: each pin passes through SYNC_STAGES flops. `sync[i]` is the last stage.
- Per-pin debounce FSM, implicit in (`stable`, `cnt`); `pins_o` = `stable`. Evaluated each cycle:
  - `sync == stable`: `cnt` <= 0 (IDLE).
  - `sync != stable` and `cnt >= D`: `stable` <= `sync`, `cnt` <= 0, and the matching edge pulse is asserted next cycle (ACCEPT).
  - `sync != stable` and `cnt < D`: `cnt` <= `cnt` + 1 (COUNT).
- Acceptance requires D+1 consecutive mismatching cycles at `sync`. Any return to the stable level restarts the count from 0.
- Latency: if the first clock edge that samples a new level is edge 0, `pins_o` changes after edge SYNC_STAGES+D. With D=0 the block is a pure synchroniser: latency SYNC_STAGES, no filtering.
- The `>=` comparison handles D being lowered below the current `cnt`: the pin accepts on the next mismatching cycle. The counter never exceeds max(D, previous D), so no wrap is possible.
- Edges:
  - `rise_o[i]` = 1 exactly in the cycle where `pins_o[i]` first shows 1 after 0.
  - `fall_o[i]` likewise for 1 -> 0.
  - The pulses are registered and coincident with the `pins_o` change. Both are never high together on one pin.
- Sticky events: `event_o[i]` <= (`event_o[i]` & ~`event_clr_i[i]`) | `rise_o[i]` | `fall_o[i]`. Set takes priority when set and clear coincide.
- Pins are fully independent; the shared D applies to each pin separately.
- No combinational path from any input to any output.

Test Plan:
- Reset: hold rst_i 2 cycles with pins_i=0 -> `pins_o`=8'hFF, `rise_o`/`fall_o`/`event_o`=0. Then release with D=0 -> `pins_o[0]` falls exactly 2 cycles after the first sampling edge, `fall_o[0]` pulses 1 cycle, `event_o[0]`=1.
- Glitch filter, D=3, pin 2 idle 1:
  - Low pulse of 3 cycles -> `pins_o[2]` stays 1, no pulse, `event_o[2]`=0.
  - Low pulse of 4 cycles -> `pins_o[2]`=0 at edge 2+3 after the first low sample, `fall_o[2]` pulses once.
- Bounce, D=5: pin toggles 1,0,1,0 every 2 cycles, then holds 0 -> exactly one `fall_o` pulse, 6 cycles after hold begins plus sync latency.
- Threshold change: D=100, pin mismatched for 20 cycles, then D set to 10 -> accept on the next cycle, single edge pulse.
- Event clear collision: assert `event_clr_i[1]` in the same cycle `rise_o[1]`=1 -> `event_o[1]` stays 1. Clear one cycle later -> `event_o[1]`=0.
- Reset mid-count: D=50, pin 4 mismatched 30 cycles, pulse rst_i -> `pins_o[4]`=1 (RESET_VAL), no pulse. With the pin held low after reset, acceptance occurs at 2+50 cycles after the first post-reset sample.
